// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO drained by a baud-rate serializer.
// Define UART_TX_PARITY_EN to add an even-parity bit between data and stop bits.
`timescale 1ns/1ps

module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 68,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned CNT_W        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] level,
  output logic             busy,
  output logic             overflow,
  input  logic             clr_ovf,
  output logic             tx
);

  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [AW:0]       PTR_ONE  = (AW + 1)'(1);
  localparam logic [BAUD_W-1:0] BAUD_ONE = BAUD_W'(1);
  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t            state;
  logic [7:0]        mem [FIFO_DEPTH];
  logic [AW:0]       wptr;
  logic [AW:0]       rptr;
  logic [BAUD_W-1:0] baud;
  logic [2:0]        bit_idx;
  logic [7:0]        shift;
  logic              baud_last;
  logic              push;
`ifdef UART_TX_PARITY_EN
  logic              par;
`endif

  // Flags come only from the registered pointers, never from wr_en.
  assign empty     = (wptr == rptr);
  assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign level     = CNT_W'(wptr - rptr);
  assign push      = wr_en && !full;
  assign baud_last = (baud == BAUD_MAX);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr[AW-1:0]] <= wr_data;
    end
  end

  // Write side; a dropped push wins over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + PTR_ONE;
      end
      if (wr_en && full) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

  // Serializer; it is the only consumer of the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rptr    <= '0;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (!empty) begin
            shift <= mem[rptr[AW-1:0]];
`ifdef UART_TX_PARITY_EN
            par   <= ^mem[rptr[AW-1:0]];
`endif
            rptr  <= rptr + PTR_ONE;
            baud  <= '0;
            tx    <= 1'b0;
            busy  <= 1'b1;
            state <= START;
          end
        end
        START: begin
          if (baud_last) begin
            baud    <= '0;
            bit_idx <= '0;
            tx      <= shift[0];
            state   <= DATA;
          end else begin
            baud <= baud + BAUD_ONE;
          end
        end
        DATA: begin
          if (baud_last) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx    <= par;
              state <= PARITY;
`else
              tx    <= 1'b1;
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= shift >> 1;
              tx      <= shift[1];
            end
          end else begin
            baud <= baud + BAUD_ONE;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_last) begin
            baud  <= '0;
            tx    <= 1'b1;
            state <= STOP;
          end else begin
            baud <= baud + BAUD_ONE;
          end
        end
`endif
        STOP: begin
          if (baud_last) begin
            baud  <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            baud <= baud + BAUD_ONE;
          end
        end
        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: frame timing, FIFO order, overflow and reset.
`timescale 1ns/1ps

module tb_uart_tx_fifo;

  localparam int unsigned CPB   = 68;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = 5;
`ifdef UART_TX_PARITY_EN
  localparam int NSEG = 11;
`else
  localparam int NSEG = 10;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          clr_ovf = 1'b0;
  logic          full, empty, busy, overflow, tx;
  logic [CW-1:0] level;

  int total = 0;
  int bad   = 0;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .level(level), .busy(busy),
    .overflow(overflow), .clr_ovf(clr_ovf), .tx(tx)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1;
    wr_data = d;
    @(posedge clk);
    #1 wr_en = 1'b0;
  endtask

  // Receives one frame; reports the decoded byte, parity bit, whether every
  // segment was a stable CPB-cycle level with busy high, and negedges waited.
  task automatic rx_frame(output logic [7:0] data, output logic par,
                          output logic shape_ok, output int waited,
                          output logic [CW-1:0] lvl0);
    logic v, segv;
    data = '0; par = 1'b0; shape_ok = 1'b1; waited = 0; lvl0 = '0; segv = 1'b0;
    while (waited < 2000) begin
      @(negedge clk);
      waited++;
      if (tx === 1'b0) break;
    end
    if (tx !== 1'b0) begin
      shape_ok = 1'b0;
      return;
    end
    lvl0 = level;
    for (int s = 0; s < NSEG; s++) begin
      for (int c = 0; c < int'(CPB); c++) begin
        if (s != 0 || c != 0) @(negedge clk);
        v = tx;
        if (busy !== 1'b1) shape_ok = 1'b0;
        if (c == 0) begin
          segv = v;
          if (s >= 1 && s <= 8) data[s-1] = v;
          if (s == 9 && NSEG == 11) par = v;
        end else if (v !== segv) begin
          shape_ok = 1'b0;
        end
      end
    end
    if (segv !== 1'b1) shape_ok = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    total += 6;
    if (tx !== 1'b1) begin bad++; $display("FAIL rst_tx: got %b want 1", tx); end
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    if (full !== 1'b0) begin bad++; $display("FAIL rst_full: got %b want 0", full); end
    if (empty !== 1'b1) begin bad++; $display("FAIL rst_empty: got %b want 1", empty); end
    if (level !== 5'd0) begin bad++; $display("FAIL rst_level: got %0d want 0", level); end
    if (overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf: got %b want 0", overflow); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single;
    logic [7:0] d; logic p, ok; int w; logic [CW-1:0] l0;
    push(8'h55);
    rx_frame(d, p, ok, w, l0);
    total += 4;
    if (w !== 2) begin bad++; $display("FAIL single_latency: got %0d want 2", w); end
    if (ok !== 1'b1) begin bad++; $display("FAIL single_shape: got %b want 1", ok); end
    if (d !== 8'h55) begin bad++; $display("FAIL single_data: got %h want 55", d); end
    if (l0 !== 5'd0) begin bad++; $display("FAIL single_level: got %0d want 0", l0); end
    @(negedge clk);
    total += 2;
    if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_end: got %b want 0", busy); end
    if (empty !== 1'b1) begin bad++; $display("FAIL single_empty_end: got %b want 1", empty); end
  endtask

  task automatic test_burst;
    logic [7:0] d [3]; logic p [3]; logic ok [3]; int w [3]; logic [CW-1:0] l0 [3];
    logic [7:0] exp_d [3];
    int exp_w [3];
    int pk;
    exp_d[0] = 8'h41; exp_d[1] = 8'h42; exp_d[2] = 8'h43;
    exp_w[0] = 3; exp_w[1] = 2; exp_w[2] = 2;
    pk = 0;
    fork
      begin
        for (int i = 0; i < 3; i++) rx_frame(d[i], p[i], ok[i], w[i], l0[i]);
      end
      begin
        @(negedge clk); wr_en = 1'b1; wr_data = 8'h41;
        @(negedge clk); if (int'(level) > pk) pk = int'(level); wr_data = 8'h42;
        @(negedge clk); if (int'(level) > pk) pk = int'(level); wr_data = 8'h43;
        @(negedge clk); if (int'(level) > pk) pk = int'(level); wr_en = 1'b0;
        @(negedge clk); if (int'(level) > pk) pk = int'(level);
      end
    join
    for (int i = 0; i < 3; i++) begin
      total += 3;
      if (d[i] !== exp_d[i]) begin bad++; $display("FAIL burst_data%0d: got %h want %h", i, d[i], exp_d[i]); end
      if (ok[i] !== 1'b1) begin bad++; $display("FAIL burst_shape%0d: got %b want 1", i, ok[i]); end
      if (w[i] !== exp_w[i]) begin bad++; $display("FAIL burst_gap%0d: got %0d want %0d", i, w[i], exp_w[i]); end
    end
    total++;
    if (pk !== 2) begin bad++; $display("FAIL burst_peak: got %0d want 2", pk); end
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL burst_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_overflow;
    @(negedge clk);
    wr_en = 1'b1; wr_data = 8'h10;
    for (int i = 1; i < 17; i++) begin
      @(negedge clk);
      wr_data = 8'(8'h10 + i);
    end
    @(negedge clk);
    total += 3;
    if (full !== 1'b1) begin bad++; $display("FAIL ovf_full: got %b want 1", full); end
    if (level !== 5'd16) begin bad++; $display("FAIL ovf_level17: got %0d want 16", level); end
    if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_after17: got %b want 0", overflow); end
    wr_data = 8'h99;
    @(negedge clk);
    wr_en = 1'b0;
    total += 2;
    if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_drop: got %b want 1", overflow); end
    if (level !== 5'd16) begin bad++; $display("FAIL ovf_level18: got %0d want 16", level); end
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    total++;
    if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b want 0", overflow); end
  endtask

  task automatic test_full_pop;
    logic [7:0] d; logic p, ok; int w; logic [CW-1:0] l0;
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    total += 2;
    if (busy !== 1'b0) begin bad++; $display("FAIL fp_idle_wait: got busy %b want 0", busy); end
    if (full !== 1'b1) begin bad++; $display("FAIL fp_full_pre: got %b want 1", full); end
    wr_en = 1'b1; wr_data = 8'hEE;
    @(posedge clk);
    #1 wr_en = 1'b0;
    rx_frame(d, p, ok, w, l0);
    total += 5;
    if (w !== 1) begin bad++; $display("FAIL fp_latency: got %0d want 1", w); end
    if (l0 !== 5'd15) begin bad++; $display("FAIL fp_level: got %0d want 15", l0); end
    if (d !== 8'h11) begin bad++; $display("FAIL fp_data: got %h want 11", d); end
    if (ok !== 1'b1) begin bad++; $display("FAIL fp_shape: got %b want 1", ok); end
    if (overflow !== 1'b1) begin bad++; $display("FAIL fp_ovf: got %b want 1", overflow); end
    // Remaining bytes include the wrapped entry; drops must not appear.
    for (int i = 2; i < 17; i++) begin
      rx_frame(d, p, ok, w, l0);
      total += 2;
      if (d !== 8'(8'h10 + i) || ok !== 1'b1) begin
        bad++; $display("FAIL fp_order%0d: got %h/%b want %h/1", i, d, ok, 8'(8'h10 + i));
      end
      if (w !== 2) begin bad++; $display("FAIL fp_gap%0d: got %0d want 2", i, w); end
    end
    @(negedge clk);
    total += 2;
    if (empty !== 1'b1) begin bad++; $display("FAIL fp_empty_end: got %b want 1", empty); end
    if (busy !== 1'b0) begin bad++; $display("FAIL fp_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid;
    int n;
    logic quiet;
    push(8'hA5);
    n = 0;
    while (tx !== 1'b0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    repeat (2 * CPB + CPB / 2) @(negedge clk);
    total++;
    if (tx !== 1'b0) begin bad++; $display("FAIL mid_bit1: got %b want 0", tx); end
    #2 rst = 1'b1;
    #1;
    total += 4;
    if (tx !== 1'b1) begin bad++; $display("FAIL mid_rst_tx: got %b want 1", tx); end
    if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    if (empty !== 1'b1) begin bad++; $display("FAIL mid_rst_empty: got %b want 1", empty); end
    if (overflow !== 1'b0) begin bad++; $display("FAIL mid_rst_ovf: got %b want 0", overflow); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < int'(11 * CPB); i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || empty !== 1'b1) quiet = 1'b0;
    end
    total++;
    if (quiet !== 1'b1) begin bad++; $display("FAIL mid_residual: got %b want 1", quiet); end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity;
    logic [7:0] d; logic p, ok; int w; logic [CW-1:0] l0;
    push(8'h07);
    rx_frame(d, p, ok, w, l0);
    total += 3;
    if (d !== 8'h07) begin bad++; $display("FAIL par07_data: got %h want 07", d); end
    if (p !== 1'b1) begin bad++; $display("FAIL par07_bit: got %b want 1", p); end
    if (ok !== 1'b1) begin bad++; $display("FAIL par07_shape: got %b want 1", ok); end
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL par07_end: got %b want 0", busy); end
    push(8'h03);
    rx_frame(d, p, ok, w, l0);
    total += 3;
    if (d !== 8'h03) begin bad++; $display("FAIL par03_data: got %h want 03", d); end
    if (p !== 1'b0) begin bad++; $display("FAIL par03_bit: got %b want 0", p); end
    if (ok !== 1'b1) begin bad++; $display("FAIL par03_shape: got %b want 1", ok); end
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL par03_end: got %b want 0", busy); end
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_burst;
    test_overflow;
    test_full_pop;
    test_reset_mid;
`ifdef UART_TX_PARITY_EN
    test_parity;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Buffered 8N1 UART transmitter peripheral, directly downstream of the data-memory MMIO decode that drives the board's uart_tx pin.
- The CPU store path pushes bytes into an internal FIFO.
- A baud-rate serializer drains the FIFO onto the tx line.
- Firmware can burst-write up to FIFO_DEPTH bytes without polling per byte.

Parameters:
CLKS_PER_BIT, 68, cpu_clk cycles per UART bit (7.8125 MHz / 115200 baud, rounded)
FIFO_DEPTH, 16, byte entries; power of two, minimum 2
CNT_W, $clog2(FIFO_DEPTH+1), width of the level output

Ports:
clk  input  1  CPU clock (cpu_clk domain)
rst  input  1  asynchronous active-high reset
wr_en  input  1  push strobe from MMIO store decode, one byte per asserted cycle
wr_data  input  8  byte to push
full  output  1  FIFO holds FIFO_DEPTH entries
empty  output  1  FIFO holds 0 entries
level  output  CNT_W  current FIFO occupancy
busy  output  1  serializer not in IDLE
overflow  output  1  sticky: a push was dropped
clr_ovf  input  1  clears overflow
tx  output  1  serial line, idle high

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - tx=1, busy=0, full=0, empty=1, level=0, overflow=0.
  - FIFO pointers = 0; FSM = IDLE; bit and baud counters = 0.
  - Reset mid-frame aborts the frame immediately, with tx forced to 1, and discards all FIFO contents.
- FIFO:
  - Circular buffer; read/write pointers carry one extra wrap bit.
  - level = wptr - rptr; all flags are registered-state derived, with no combinational path from wr_en.
- Push: wr_en=1 && full=0 stores wr_data and increments wptr.
- Overflow: wr_en=1 && full=1 drops the byte and sets overflow. This holds even if a pop occurs in the same cycle, because full is evaluated on pre-edge state.
- Pop: only the FSM pops, in IDLE when empty=0.
- Simultaneous push and pop (not full): level unchanged, both pointers advance.
- Pointer wrap: wrap past FIFO_DEPTH-1 to 0 is seamless; byte order is strictly FIFO.
- overflow: clr_ovf=1 clears it. If clr_ovf and a new dropped push coincide, set wins (overflow stays 1).
- FSM states:
  - IDLE: tx=1. If !empty, pop head into shift reg, go to START, baud counter = 0.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: tx=shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles, then shift right. After bit 7, go to STOP (or PARITY if enabled).
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
- tx is driven from a register, so it is glitch-free.
- Latency: byte pushed at edge N into an empty FIFO with FSM in IDLE → pop at edge N+1 → tx falls after edge N+1.
- Frame length: exactly 10*CLKS_PER_BIT cycles, plus 1 IDLE cycle between back-to-back frames.
- busy=1 in every state except IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps, so each bit boundary occurs on count==CLKS_PER_BIT-1.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: FSM adds PARITY state between DATA and STOP.
  - tx = XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles.
  - Frame is 11*CLKS_PER_BIT cycles.
- Undefined: no PARITY state or logic; 8N1 frames of 10*CLKS_PER_BIT cycles.

Test Plan:
1. Reset, then write 0x55 once → tx low for 68 cycles; then 0,1,0,1,... is wrong order, so check LSB first: data bits 1,0,1,0,1,0,1,0, 68 cycles each; then stop high. busy=1 for 680 cycles, then 0. level returns to 0 after the pop.
2. Burst-write 0x41,0x42,0x43 on consecutive cycles → level peaks at 2; three frames decode to "ABC" in order; one idle cycle between frames.
3. Write 17 bytes back-to-back with CLKS_PER_BIT=4, FIFO_DEPTH=16 → first pop frees one slot, all 17 accepted, overflow=0. Then refill past full → 18th push dropped, overflow=1. Pulse clr_ovf → overflow=0.
4. Hold wr_en while full=1 and the FSM pops in the same cycle → byte dropped, overflow=1, level decrements by 1.
5. Assert rst mid-DATA of 0xA5 → tx=1 and busy=0 immediately (asynchronously). After release: empty=1, no residual frame.
6. With UART_TX_PARITY_EN, write 0x07 → parity bit 1. Write 0x03 → parity bit 0. Each frame lasts 11*CLKS_PER_BIT cycles.
